// File: rtl/fifo_pin_buffer_pkg.sv
// fifio_pkg: default sizing constants and the count-width helper for fifo_pin_buffer
package fifio_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;
  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_pin_buffer_if.sv
// fifo_pin_buffer_if: pin-side strobes, data and status of fifo_pin_buffer
interface fifo_pin_buffer_if import fifio_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  logic                       ena;
  logic                       push_in;
  logic                       pop_in;
  logic [WIDTH-1:0]           wr_data;
  logic [WIDTH-1:0]           rd_data;
  logic [count_w(DEPTH)-1:0]  count;
  logic                       empty;
  logic                       full;
  logic                       almost_full;
  logic                       overflow;
  logic                       underflow;
  modport master (
    output ena, push_in, pop_in, wr_data,
    input  rd_data, count, empty, full, almost_full, overflow, underflow
  );
  modport slave (
    input  ena, push_in, pop_in, wr_data,
    output rd_data, count, empty, full, almost_full, overflow, underflow
  );
endinterface

// File: rtl/fifo_pin_buffer_pin_sync_edge.sv
// pin_sync_edge: 2-flop synchronizer plus delay flop giving one pulse per rising strobe edge
module pin_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic pulse
);
  logic s1_q, s2_q, dly_q, s1_d, s2_d, dly_d;
  // shift the raw strobe through the sync chain and the edge-detect delay
  always_comb begin
    s1_d  = strobe;
    s2_d  = s1_q;
    dly_d = s2_q;
  end
  // chain registers, cleared by reset
  always_ff @(posedge clk) begin
    s1_q  <= rst_n ? s1_d : 1'b0;
    s2_q  <= rst_n ? s2_d : 1'b0;
    dly_q <= rst_n ? dly_d : 1'b0;
  end
  assign pulse = s2_q & ~dly_q;
endmodule

// File: rtl/fifo_pin_buffer.sv
// fifo_pin_buffer: byte FIFO fed by synchronized pin strobes; FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
module fifo_pin_buffer import fifio_pkg::*; #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input logic             clk,
  input logic             rst_n,
  fifo_pin_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);
  logic             push_p, pop_p, push_v, pop_v, do_push, do_pop;
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  pin_sync_edge u_push (.clk(clk), .rst_n(rst_n), .strobe(bus.push_in), .pulse(push_p));
  pin_sync_edge u_pop  (.clk(clk), .rst_n(rst_n), .strobe(bus.pop_in),  .pulse(pop_p));
  // a pop frees a slot, so a push into a full FIFO still lands when paired with a pop
  always_comb begin
    push_v  = push_p & bus.ena;
    pop_v   = pop_p & bus.ena;
    do_pop  = pop_v && (count_q != '0);
    do_push = push_v && ((count_q != CW'(DEPTH)) || do_pop);
    wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = do_pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    rd_d    = do_pop ? mem_q[rptr_q] : rd_q;
    mem_d   = mem_q;
    if (do_push) mem_d[wptr_q] = bus.wr_data;
  end
  // pointers, occupancy and read register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rd_q    <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rd_q    <= rd_d;
    end
  end
  // storage array keeps its contents across reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
  assign bus.rd_data     = rd_q;
  assign bus.count       = count_q;
  assign bus.empty       = count_q == '0;
  assign bus.full        = count_q == CW'(DEPTH);
  assign bus.almost_full = count_q >= CW'(AF_LEVEL);
`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d, unf_q, unf_d;
  // sticky: dropped push, or pop seen while empty (even alongside a push)
  always_comb begin
    ovf_d = ovf_q | (push_v & ~do_push);
    unf_d = unf_q | (pop_v & (count_q == '0));
  end
  // error flag registers, cleared only by reset
  always_ff @(posedge clk) begin
    ovf_q <= rst_n ? ovf_d : 1'b0;
    unf_q <= rst_n ? unf_d : 1'b0;
  end
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_pin_buffer.sv
// tb_fifo_pin_buffer: randomized and directed scoreboard bench for fifo_pin_buffer
module tb_fifo_pin_buffer;
  localparam int W = 8, D = 8, AF = 6;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0, errors = 0;
  typedef struct {
    int         due;
    int         cnt;
    logic [7:0] rd;
    bit         ovf;
    bit         unf;
  } exp_t;
  exp_t       sb[$];
  logic [7:0] mq[$];
  logic [7:0] rd_m = 8'h00;
  bit         ovf_m = 1'b0, unf_m = 1'b0;
  fifo_pin_buffer_if #(.WIDTH(W), .DEPTH(D)) bus ();
  fifo_pin_buffer #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // monitor: compare every expectation that falls due at this cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.due < cyc) chk("stale_expectation", e.due, cyc);
      chk("count", int'(bus.count), e.cnt);
      chk("empty", int'(bus.empty), int'(e.cnt == 0));
      chk("full", int'(bus.full), int'(e.cnt == D));
      chk("almost_full", int'(bus.almost_full), int'(e.cnt >= AF));
      chk("rd_data", int'(bus.rd_data), int'(e.rd));
`ifdef FIFO_ERR_FLAGS_EN
      chk("overflow", int'(bus.overflow), int'(e.ovf));
      chk("underflow", int'(bus.underflow), int'(e.unf));
`else
      chk("overflow", int'(bus.overflow), 0);
      chk("underflow", int'(bus.underflow), 0);
`endif
    end
  end
  function automatic exp_t snap(input int due);
    exp_t e;
    e.due = due;
    e.cnt = mq.size();
    e.rd  = rd_m;
    e.ovf = ovf_m;
    e.unf = unf_m;
    return e;
  endfunction
  // one pin operation: strobes high for hi cycles then low for lo cycles
  task automatic op(input bit p, input bit q, input logic [7:0] d, input bit en = 1'b1,
                    input int hi = 3, input int lo = 3);
    bit was_empty, pop_ok, push_ok;
    @(negedge clk);
    bus.ena = en; bus.push_in = p; bus.pop_in = q; bus.wr_data = d;
    sb.push_back(snap(cyc + 2));
    if (en) begin
      was_empty = mq.size() == 0;
      pop_ok    = q && !was_empty;
      push_ok   = p && (mq.size() < D || pop_ok);
      if (pop_ok) rd_m = mq.pop_front();
      if (push_ok) mq.push_back(d);
      if (q && was_empty) unf_m = 1'b1;
      if (p && !push_ok) ovf_m = 1'b1;
    end
    sb.push_back(snap(cyc + 3));
    repeat (hi) @(negedge clk);
    bus.push_in = 1'b0; bus.pop_in = 1'b0;
    repeat (lo) @(negedge clk);
    bus.ena = 1'b1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mq.delete();
    rd_m = 8'h00; ovf_m = 1'b0; unf_m = 1'b0;
    sb.push_back(snap(cyc + 1));
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    bus.ena = 1'b1; bus.push_in = 1'b0; bus.pop_in = 1'b0; bus.wr_data = 8'h00;
    repeat (3) @(negedge clk);
    do_reset();
    repeat (4) @(negedge clk);
    op(1, 0, 8'hA5); op(1, 0, 8'h3C); op(0, 1, 8'h00); op(0, 1, 8'h00);
    for (int i = 1; i <= 8; i++) op(1, 0, 8'(i));
    op(1, 0, 8'hFF);
    repeat (8) op(0, 1, 8'h00);
    for (int i = 0; i < 8; i++) op(1, 0, 8'h10 + 8'(i));
    op(1, 1, 8'h77);
    repeat (8) op(0, 1, 8'h00);
    op(1, 1, 8'h5A);
    do_reset();
    repeat (3) op(1, 0, 8'h99, 1'b0);
    op(1, 0, 8'h42);
    repeat (4) op(1, 0, 8'h60);
    do_reset();
    op(1, 0, 8'hC3); op(0, 1, 8'h00);
    for (int i = 0; i < 150; i++)
      op(1'($urandom), 1'($urandom), 8'($urandom), ($urandom_range(0, 7) != 0),
         $urandom_range(2, 4), $urandom_range(2, 4));
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never checked", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_pin_buffer.md
# fifo_pin_buffer

Byte-wide synchronous FIFO sitting directly behind the `tt_um_example` pin interface. It accepts raw asynchronous push/pop strobes from the bidirectional pins, synchronizes them and edge-detects them. It stores `ui_in` bytes on push and presents the popped byte plus status flags for `uo_out`/`uio_out`. The top level is reduced to pure pin wiring around this block.

## Interface
- `WIDTH`, 8: data width in bits.
- `DEPTH`, 8: entries; power of two, ≥ 2.
- `AF_LEVEL`, DEPTH-2: `almost_full` asserts when `count` ≥ this value.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `ena`  in  1  design-select; when low, push/pop pulses are discarded.
- `push_in`  in  1  raw asynchronous push strobe (pin).
- `pop_in`  in  1  raw asynchronous pop strobe (pin).
- `wr_data`  in  WIDTH  byte to store; sampled on the push action edge.
- `rd_data`  out  WIDTH  last popped byte, registered.
- `count`  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- `empty`  out  1  count == 0.
- `full`  out  1  count == DEPTH.
- `almost_full`  out  1  count ≥ AF_LEVEL.
- `overflow`  out  1  sticky error; present only with FIFO_ERR_FLAGS_EN, else tied 0.
- `underflow`  out  1  sticky error; present only with FIFO_ERR_FLAGS_EN, else tied 0.

## Operation
- Each strobe passes through a 2-flop synchronizer and a delay flop. Internal pulse = sync & ~delay, which gives exactly one cycle per rising edge regardless of strobe width.
- Pulse qualified by `ena`. Synchronizers keep running while `ena` is low, so the first edge after re-enable is not lost or duplicated.
- Push (not full): `mem[wptr] <= wr_data`, `wptr` increments, `count` increments.
- Pop (not empty): `rd_data <= mem[rptr]`, `rptr` increments, `count` decrements.
- Pointers are log2(DEPTH) bits and wrap naturally DEPTH-1 → 0. `count` is a separate register; flags derive from `count` only.
- Push while full: dropped; memory and wptr unchanged.
- Pop while empty: ignored; `rd_data` holds its value.
- Push and pop in the same cycle:
  - Not empty: both execute, count unchanged.
  - Full: both execute (pop frees the slot), count stays DEPTH.
  - Empty: push executes, pop ignored (no fall-through).
- Reset (any cycle, mid-operation included): pointers, count, synchronizer/delay flops, `rd_data`, error flags all 0. Memory contents are not reset.
- Status outputs after reset: `empty`=1, `full`=0, `almost_full`=0.

## Timing
- Raw strobe rising before edge E0 → s1 set at E0, s2 at E1, pulse high in cycle E1–E2, action at E2.
- `count`/flags update after E2. `rd_data` is valid after E2.
- Pin-to-effect latency: 3 clock edges. `wr_data` must be stable at E2.
- Minimum strobe high and low time: 2 clk cycles each; shorter pulses may be missed.
- Back-to-back operations: at most one push and one pop per 4 cycles (pin limited); the core accepts one of each per cycle.
- Flags are registered-equivalent: they change only on the edge that changes `count`.

## Configuration
- `FIFO_ERR_FLAGS_EN` defined:
  - `overflow` sets on a push pulse while full.
  - `underflow` sets on a pop pulse while empty (including the empty simultaneous case).
  - Both flags hold until `rst_n` low.
- Not defined: both outputs constant 0 and no flops are inferred.

## Structure
- Shared package `fifio_pkg`: default `WIDTH`/`DEPTH` constants and a `count_w` function (`$clog2(DEPTH+1)`).
- Sub-module `pin_sync_edge` (2-flop sync + delay flop + rising-edge pulse, synchronous active-low reset) instantiated twice, once for push and once for pop.
- Storage is an inferred register array in `fifo_pin_buffer`.

## Test plan
- Reset then idle → `empty`=1, `full`=0, `count`=0, `rd_data`=0x00, error flags 0.
- Push 0xA5, 0x3C (strobes 3 cycles high/low), then pop twice → `rd_data` 0xA5 then 0x3C, each appearing 3 edges after the pop rising edge; `count` ends at 0.
- Push 8 bytes 0x01..0x08 → `almost_full` at count 6, `full` at 8. Ninth push 0xFF dropped and `overflow`=1 (macro on). Pop 8 times → 0x01..0x08 returned in order, with pointers wrapped.
- Full FIFO, push and pop strobes raised together → `count` stays 8 and `rd_data` = oldest byte. Empty FIFO, both strobes together → `count`=1, `underflow`=1, `rd_data` unchanged.
- `ena`=0 with 3 push strobes → `count` stays 0. Raise `ena`, one strobe → `count`=1, confirming no spurious pulse on enable.
- Assert `rst_n`=0 for 1 cycle at count=5 → next cycle `count`=0, `empty`=1, error flags cleared. A subsequent push/pop returns the newly written byte.
